// File: rtl/config_spi_loader_pkg.sv
// Shared configuration-path definitions: frame length of the configuration store
// and the loader state encoding.
package config_spi_loader_pkg;

    // Width of the configuration shift register; one valid frame carries this many bits.
    localparam int ConfigFrameBits = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/config_spi_loader_if.sv
// Pin-side SPI signals plus the strobe/status signals toward the configuration store.
interface config_spi_loader_if;
    logic sclk;
    logic csN;
    logic mosi;
    logic miso;
    logic misoOe;
    logic serialEn;
    logic serialIn;
    logic serialOut;
    logic busy;
    logic frameDone;
    logic frameError;

    // The loader drives the strobes and status; pins and store drive the rest.
    modport master (
        input  sclk, csN, mosi, serialOut,
        output miso, misoOe, serialEn, serialIn, busy, frameDone, frameError
    );

    modport slave (
        output sclk, csN, mosi, serialOut,
        input  miso, misoOe, serialEn, serialIn, busy, frameDone, frameError
    );
endinterface

// File: rtl/config_spi_loader_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin with registered rise/fall events.
module sync_edge_detect #(
    parameter int   SyncStages = 2,
    parameter logic IdleVal    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] chain_q;
    logic                  prev_q;
    logic                  rise_q;
    logic                  fall_q;

    // Events are registered so every event lands one cycle after the sync output changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {SyncStages{IdleVal}};
            prev_q  <= IdleVal;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SyncStages-2:0], d_i};
            prev_q  <= chain_q[SyncStages-1];
            rise_q  <= chain_q[SyncStages-1] & ~prev_q;
            fall_q  <= ~chain_q[SyncStages-1] & prev_q;
        end
    end

    assign sync_o = chain_q[SyncStages-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/config_spi_loader.sv
// SPI mode-0 front-end that turns pin-level shifts into single-cycle store strobes
// and reports whether each chip-select frame carried exactly one store-width of bits.
module config_spi_loader
    import config_spi_loader_pkg::*;
#(
    parameter int FrameBits  = ConfigFrameBits,
    parameter int SyncStages = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    config_spi_loader_if.master  bus
);

    localparam int CountWidth = $clog2(FrameBits + 2);
    localparam logic [CountWidth-1:0] FrameCount = CountWidth'(FrameBits);

    logic sclkSyncUnused;
    logic rise;
    logic fall;
    logic csS;
    logic start;
    logic stop;

    logic [SyncStages-1:0] mosiSync_q;
    logic                  mosiAl_q;

    state_e                state_q,      state_d;
    logic [CountWidth-1:0] bitCount_q,   bitCount_d;
    logic                  miso_q,       miso_d;
    logic                  serialEn_q,   serialEn_d;
    logic                  serialIn_q,   serialIn_d;
    logic                  frameDone_q,  frameDone_d;
    logic                  frameError_q, frameError_d;

    sync_edge_detect #(
        .SyncStages (SyncStages),
        .IdleVal    (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.sclk),
        .sync_o  (sclkSyncUnused),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // A falling chip select starts a frame, a rising one ends it.
    sync_edge_detect #(
        .SyncStages (SyncStages),
        .IdleVal    (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.csN),
        .sync_o  (csS),
        .rise_o  (stop),
        .fall_o  (start)
    );

    // mosi gets one extra flop so its value lines up with the registered sclk rise event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosiSync_q <= '0;
            mosiAl_q   <= 1'b0;
        end else begin
            mosiSync_q <= {mosiSync_q[SyncStages-2:0], bus.mosi};
            mosiAl_q   <= mosiSync_q[SyncStages-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bitCount_q   <= '0;
            miso_q       <= 1'b0;
            serialEn_q   <= 1'b0;
            serialIn_q   <= 1'b0;
            frameDone_q  <= 1'b0;
            frameError_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCount_q   <= bitCount_d;
            miso_q       <= miso_d;
            serialEn_q   <= serialEn_d;
            serialIn_q   <= serialIn_d;
            frameDone_q  <= frameDone_d;
            frameError_q <= frameError_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bitCount_d   = bitCount_q;
        miso_d       = miso_q;
        serialEn_d   = 1'b0;
        serialIn_d   = serialIn_q;
        frameDone_d  = 1'b0;
        frameError_d = frameError_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ACTIVE;
                    bitCount_d   = '0;
                    frameError_d = 1'b0;
                    miso_d       = bus.serialOut;
                    // An edge arriving together with start is the frame's first bit.
                    if (rise && !csS) begin
                        serialEn_d = 1'b1;
                        serialIn_d = mosiAl_q;
                        bitCount_d = CountWidth'(1);
                    end
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_d = IDLE;
                    if (bitCount_q == FrameCount) begin
                        frameDone_d = 1'b1;
                    end else begin
                        frameError_d = 1'b1;
                    end
                end else begin
                    if (rise && !csS) begin
                        serialEn_d = 1'b1;
                        serialIn_d = mosiAl_q;
                        if (bitCount_q != '1) begin
                            bitCount_d = bitCount_q + CountWidth'(1);
                        end
                    end
                    // The store has already shifted, so this presents the next MSB.
                    if (fall) begin
                        miso_d = bus.serialOut;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.miso       = miso_q;
    assign bus.misoOe     = (state_q == ACTIVE);
    assign bus.busy       = (state_q == ACTIVE);
    assign bus.serialEn   = serialEn_q;
    assign bus.serialIn   = serialIn_q;
    assign bus.frameDone  = frameDone_q;
    assign bus.frameError = frameError_q;

endmodule
